ser2par_stream: RTL
===================

Name: ser2par_stream

Overview:
- Parametrised serial-to-parallel converter; successor to the fixed 8-bit, free-running converter.
- Adds:
  - generic word width and bit order;
  - input bit-valid qualifier;
  - start-of-frame realignment;
  - small output FIFO with valid/ready handshake;
  - overflow reporting.
- Sits between a serial link front end and a word-oriented consumer that may stall.

Parameters:
- WIDTH, 8, data bits per word (>=2).
- MSB_FIRST, 1, 1: first received bit lands in dout[WIDTH-1]; 0: first bit lands in dout[0].
- OUT_DEPTH, 2, output FIFO depth in words (power of two, >=2).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- din  in  1  serial data bit.
- din_vld  in  1  din sampled only when 1.
- sof  in  1  start-of-frame; qualified by din_vld; marks din as bit 0 of a new word.
- dout  out  WIDTH  head-of-FIFO word; valid when dout_vld=1.
- dout_vld  out  1  FIFO not empty.
- dout_rdy  in  1  consumer accepts; pop when dout_vld & dout_rdy.
- ovf  out  1  one-cycle pulse: completed word dropped because FIFO full.
- par_err  out  1  only when PARITY_EN is defined (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Clears the shift register, bit counter and FIFO pointers.
  - Outputs: dout=0, dout_vld=0, ovf=0, par_err=0.
  - Reset mid-word or with buffered words discards everything.
  - The first qualified bit after reset is bit 0.
- Bit counter cnt (0..WIDTH-1) advances only on din_vld=1; din_vld=0 cycles hold all state (gaps allowed anywhere).
- Shifting:
  - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], din}.
  - MSB_FIRST=0: shreg <= {din, shreg[WIDTH-1:1]}.
- sof & din_vld:
  - The partial word is discarded; din becomes bit 0; cnt <= 1.
  - sof with cnt already 0 is harmless.
  - sof without din_vld is ignored.
- Word completion: on the qualified bit with cnt==WIDTH-1, the assembled word (including that bit) is pushed and cnt wraps to 0.
- Latency: the word appears on dout with dout_vld=1 one clock after its last bit, if the FIFO was empty.
- FIFO behaviour:
  - Standard synchronous FIFO with first-word-fall-through.
  - dout is stable while dout_vld=1 and dout_rdy=0.
  - Push and pop in the same cycle are both performed.
  - When full, a pop in the same cycle frees the slot, so the push succeeds with no ovf.
  - Full and no pop at word completion: the word is dropped, ovf=1 for exactly that cycle, and FIFO contents are unchanged.
  - Pop while empty: ignored.
- Back-to-back words with continuous din_vld: one word every WIDTH cycles; no bubbles while the consumer keeps dout_rdy=1.

Optional Feature:
- Macro: SER2PAR_STREAM_PARITY_EN.
- Defined:
  - Each word is followed by one even-parity bit (frame = WIDTH+1 qualified bits).
  - Small FSM: DATA (collect WIDTH bits) -> PAR (one bit) -> DATA.
  - sof in either state realigns to DATA with cnt=1.
  - Good parity: the word is pushed on the parity-bit cycle (latency counted from the parity bit).
  - Bad parity: the word is dropped and par_err pulses for one cycle.
  - ovf and par_err are mutually exclusive: a bad-parity word is never pushed.
- Undefined: no parity bit, no PAR state, no par_err port.

Decomposition:
- Package ser2par_stream_pkg:
  - FSM state typedef (ST_DATA, ST_PAR);
  - function clog2 for counter/pointer widths;
  - parity helper function.
- Sub-module ser2par_fifo:
  - Parameters W, DEPTH.
  - Ports push/pop/full/empty/data.
  - Reusable synchronous FIFO instantiated once.
- The top level holds the shifter, counter and FSM.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, dout_rdy=1, bits 1,0,1,0,0,1,0,1 with continuous din_vld -> dout=8'hA5, dout_vld high exactly one cycle, one clock after the 8th bit.
2. MSB_FIRST=0, bits 1,0,1,1,0,0,0,1 with random din_vld gaps -> dout=8'h8D; no output during gaps.
3. OUT_DEPTH=2, dout_rdy=0, stream 0x11, 0x22, 0x33 -> ovf pulses once on the 0x33 completion; then dout_rdy=1 yields 0x11, 0x22 only, then dout_vld=0.
4. Send 3 bits, then sof with 8 bits forming 0xC3 -> single output 0xC3, no word from the partial bits.
5. After 5 bits, with one word buffered, hold rst_n=0 for one cycle -> dout_vld=0 next cycle; the next 8 bits 0x5A are output as 0x5A.
6. PARITY_EN defined: 0xA5 followed by parity 0 -> word output; 0xA5 followed by parity 1 -> par_err one-cycle pulse, no word, dout_vld stays 0.

Source files
------------

// File: rtl/ser2par_stream_pkg.sv
// ser2par_stream_pkg: shared FSM state type and helpers for ser2par_stream.
//   state_t : ST_DATA collects word bits, ST_PAR takes the trailing parity bit
//   clog2   : counter/pointer width helper
//   par_ok  : even-parity check of a word plus its parity bit
package ser2par_stream_pkg;

   typedef enum logic {ST_DATA, ST_PAR} state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

   // 1 when word bits and parity bit together hold an even number of ones
   function automatic logic par_ok(input logic [63:0] w, input logic p);
      return ~^{w, p};
   endfunction

endpackage

// File: rtl/ser2par_fifo.sv
// ser2par_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst_n      : clock, synchronous active-low reset
//   push, din       : write request and data (refused when full unless popping)
//   pop             : read request (ignored when empty)
//   dout            : head word, forced to 0 while empty
//   full, empty     : occupancy flags
module ser2par_fifo
   import ser2par_stream_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr, rd_ptr;
   logic         do_pop, do_push;

   // extra pointer MSB distinguishes full from empty when the indices match
   assign empty   = wr_ptr == rd_ptr;
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // a simultaneous pop frees the slot, so a push into a full FIFO still lands
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;

endmodule

// File: rtl/ser2par_stream.sv
// ser2par_stream: serial-to-parallel converter with SOF realignment and an
// output FIFO with valid/ready handshake.
//   clk, rst_n        : clock, synchronous active-low reset
//   din, din_vld, sof : serial bit, bit qualifier, start-of-frame (qualified)
//   dout, dout_vld    : head-of-FIFO word and its valid
//   dout_rdy          : consumer accepts the head word
//   ovf               : one-cycle pulse when a completed word hits a full FIFO
//   par_err           : one-cycle pulse on a bad parity bit (parity build only)
// Define SER2PAR_STREAM_PARITY_EN to expect one even-parity bit after each word.
module ser2par_stream
   import ser2par_stream_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1,
   parameter int OUT_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din,
   input  logic             din_vld,
   input  logic             sof,
   output logic [WIDTH-1:0] dout,
   output logic             dout_vld,
   input  logic             dout_rdy,
   output logic             ovf
`ifdef SER2PAR_STREAM_PARITY_EN
   ,
   output logic             par_err
`endif
);

   localparam int              CW   = clog2(WIDTH);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] shreg, shreg_nx, push_word;
   logic [CW-1:0]    cnt, cnt_nx;
   logic             push, full, empty, ovf_nx;
`ifdef SER2PAR_STREAM_PARITY_EN
   state_t           state, state_nx;
   logic             perr_nx;
`endif

   always_comb begin
      shreg_nx  = MSB_FIRST ? {shreg[WIDTH-2:0], din} : {din, shreg[WIDTH-1:1]};
      cnt_nx    = cnt;
      push      = 1'b0;
`ifdef SER2PAR_STREAM_PARITY_EN
      // on the parity bit the register already holds the complete word
      push_word = shreg;
      state_nx  = state;
      perr_nx   = 1'b0;
      if (din_vld) begin
         if (sof) begin
            state_nx = ST_DATA;
            cnt_nx   = CW'(1);
         end else if (state == ST_PAR) begin
            state_nx = ST_DATA;
            cnt_nx   = '0;
            push     = par_ok(64'(shreg), din);
            perr_nx  = !push;
         end else if (cnt == LAST) begin
            state_nx = ST_PAR;
            cnt_nx   = '0;
         end else begin
            cnt_nx = cnt + CW'(1);
         end
      end
`else
      push_word = shreg_nx;
      if (din_vld) begin
         push   = !sof && cnt == LAST;
         cnt_nx = sof ? CW'(1) : push ? '0 : cnt + CW'(1);
      end
`endif
      // a pop in the same cycle makes room, so only a stalled consumer drops words
      ovf_nx = push && full && !dout_rdy;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shreg   <= '0;
         cnt     <= '0;
         ovf     <= 1'b0;
`ifdef SER2PAR_STREAM_PARITY_EN
         state   <= ST_DATA;
         par_err <= 1'b0;
`endif
      end else begin
         if (din_vld) shreg <= shreg_nx;
         cnt     <= cnt_nx;
         ovf     <= ovf_nx;
`ifdef SER2PAR_STREAM_PARITY_EN
         state   <= state_nx;
         par_err <= perr_nx;
`endif
      end
   end

   ser2par_fifo #(.W(WIDTH), .DEPTH(OUT_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (push_word),
      .pop   (dout_rdy),
      .dout  (dout),
      .full  (full),
      .empty (empty)
   );

   assign dout_vld = !empty;

endmodule
